// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired CPU controller: opcodes, ALU codes, state encoding, IR fields.
package cpu_ctrl_pkg;

    localparam int unsigned OPW    = 5;
    localparam int unsigned ALUW   = 4;
    localparam int unsigned IRW    = 32;
    localparam int unsigned STW    = 4;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;

    localparam logic [OPW-1:0] OP_LD   = 5'd0;
    localparam logic [OPW-1:0] OP_LDI  = 5'd1;
    localparam logic [OPW-1:0] OP_ST   = 5'd2;
    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SUB  = 5'd4;
    localparam logic [OPW-1:0] OP_AND  = 5'd5;
    localparam logic [OPW-1:0] OP_OR   = 5'd6;
    localparam logic [OPW-1:0] OP_NOP  = 5'd26;
    localparam logic [OPW-1:0] OP_HALT = 5'd27;

    localparam logic [ALUW-1:0] ALU_PASS = 4'd0;
    localparam logic [ALUW-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALUW-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALUW-1:0] ALU_AND  = 4'd3;
    localparam logic [ALUW-1:0] ALU_OR   = 4'd4;

    typedef enum logic [STW-1:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // One-hot instruction class produced by the decoder
    typedef struct packed {
        logic alu;
        logic ldi;
        logic ld;
        logic st;
        logic nop;
        logic halt;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: one-hot instruction class plus ALU function for register ops.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW-1:0]  opcode_i,
    output iclass_t         cls_c_o,
    output logic [ALUW-1:0] alu_op_c_o
);

    always_comb begin
        cls_c_o    = '0;
        alu_op_c_o = ALU_PASS;
        case (opcode_i)
            OP_LD:   cls_c_o.ld   = 1'b1;
            OP_LDI:  cls_c_o.ldi  = 1'b1;
            OP_ST:   cls_c_o.st   = 1'b1;
            OP_ADD:  begin cls_c_o.alu = 1'b1; alu_op_c_o = ALU_ADD; end
            OP_SUB:  begin cls_c_o.alu = 1'b1; alu_op_c_o = ALU_SUB; end
            OP_AND:  begin cls_c_o.alu = 1'b1; alu_op_c_o = ALU_AND; end
            OP_OR:   begin cls_c_o.alu = 1'b1; alu_op_c_o = ALU_OR;  end
            OP_NOP:  cls_c_o.nop  = 1'b1;
            OP_HALT: cls_c_o.halt = 1'b1;
            default: cls_c_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer; strobes are Moore-decoded from the state register and ir.
// Optional CTRL_SINGLE_STEP_EN adds a step input: one instruction per rising edge of step.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [IRW-1:0]  ir,
    input  logic            mem_ready,
    output logic            pco,
    output logic            pci,
    output logic            inc_pc,
    output logic            mari,
    output logic            mdri,
    output logic            mdro,
    output logic            iri,
    output logic            yi,
    output logic            zi,
    output logic            zlo,
    output logic            read,
    output logic            write,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout,
    output logic            cout,
    output logic [ALUW-1:0] alu_op,
    output logic            halted,
    output logic            illegal,
    output logic [STW-1:0]  state
);

    state_t          state_q, state_d;
    logic            held_q;
    iclass_t         cls_c;
    logic [ALUW-1:0] dec_alu_c;
    logic            start_ok_c;
    state_t          end_next_c;
    logic            unused_ir_c;

    ctrl_decode u_decode (
        .opcode_i   (ir[OP_MSB:OP_LSB]),
        .cls_c_o    (cls_c),
        .alu_op_c_o (dec_alu_c)
    );

    // Register fields are steered in the datapath; only the opcode is decoded here
    assign unused_ir_c = ^ir[OP_LSB-1:0];

`ifdef CTRL_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) step_q <= 1'b0;
        else        step_q <= step;
    end

    assign start_ok_c = run && step && !step_q;
    assign end_next_c = S_IDLE;
`else
    assign start_ok_c = run;
    assign end_next_c = run ? S_T0 : S_IDLE;
`endif

    // held_q marks a repeated (wait) cycle of the same state
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= (state_d == state_q);
        end
    end

    assign state = STW'(state_q);

    always_comb begin
        state_d = state_q;
        pco = 1'b0; pci = 1'b0; inc_pc = 1'b0; mari = 1'b0; mdri = 1'b0; mdro = 1'b0;
        iri = 1'b0; yi = 1'b0; zi = 1'b0; zlo = 1'b0; read = 1'b0; write = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; cout = 1'b0;
        alu_op = ALU_PASS; halted = 1'b0; illegal = 1'b0;
        case (state_q)
            S_IDLE: if (start_ok_c) state_d = S_T0;
            S_T0: begin
                pco = 1'b1; mari = 1'b1; inc_pc = 1'b1; zi = 1'b1; alu_op = ALU_ADD;
                state_d = S_T1;
            end
            S_T1: begin
                read = 1'b1; mdri = 1'b1;
                if (!held_q) begin zlo = 1'b1; pci = 1'b1; end
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                mdro = 1'b1; iri = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (cls_c.halt) begin
                    state_d = S_HALT;
                end else if (cls_c.nop || cls_c.illegal) begin
                    illegal = cls_c.illegal;
                    state_d = end_next_c;
                end else begin
                    grb = 1'b1; rout = 1'b1; yi = 1'b1;
                    state_d = S_T4;
                end
            end
            S_T4: begin
                zi = 1'b1;
                if (cls_c.alu) begin
                    grc = 1'b1; rout = 1'b1; alu_op = dec_alu_c;
                end else if (cls_c.ldi || cls_c.ld || cls_c.st) begin
                    cout = 1'b1; alu_op = ALU_ADD;
                end
                state_d = S_T5;
            end
            S_T5: begin
                zlo = 1'b1;
                if (cls_c.ld || cls_c.st) begin
                    mari = 1'b1;
                    state_d = S_T6;
                end else begin
                    gra = 1'b1; rin = 1'b1;
                    state_d = end_next_c;
                end
            end
            S_T6: begin
                mdri = 1'b1;
                if (cls_c.st) begin
                    gra = 1'b1; rout = 1'b1;
                    state_d = S_T7;
                end else begin
                    read = 1'b1;
                    if (mem_ready) state_d = S_T7;
                end
            end
            S_T7: begin
                if (cls_c.st) begin
                    write = 1'b1;
                    if (mem_ready) state_d = end_next_c;
                end else begin
                    mdro = 1'b1; gra = 1'b1; rin = 1'b1;
                    state_d = end_next_c;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer (default build, CTRL_SINGLE_STEP_EN undefined): directed
// scenarios with literal expectations, then random stimulus against a micro-step list model.
module tb_control_sequencer;

    localparam int B_PCO = 19, B_PCI = 18, B_INC = 17, B_MARI = 16, B_MDRI = 15, B_MDRO = 14;
    localparam int B_IRI = 13, B_YI = 12, B_ZI = 11, B_ZLO = 10, B_RD = 9, B_WR = 8;
    localparam int B_GRA = 7, B_GRB = 6, B_GRC = 5, B_RIN = 4, B_ROUT = 3, B_COUT = 2;
    localparam int B_HLT = 1, B_ILL = 0;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic        pco, pci, inc_pc, mari, mdri, mdro, iri, yi, zi, zlo, rd, wr;
    logic        gra, grb, grc, rin, rout, cout, halted, illegal;
    logic [3:0]  alu_op, state;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [3:0]  st;
        logic [19:0] strb;
        logic [19:0] first_only;
        logic [3:0]  alu;
        bit          waits;
    } step_t;

    // Model: 0 idle, 1 running the micro-step list, 2 halted
    int    mode = 0;
    step_t seq[$];
    int    idx = 0;
    bit    first = 1'b1;
    bit    halts_after = 1'b0;

    logic [3:0]  tr_st[$];
    logic [19:0] tr_vec[$];
    logic [3:0]  tr_alu[$];

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .pco(pco), .pci(pci), .inc_pc(inc_pc), .mari(mari), .mdri(mdri), .mdro(mdro),
        .iri(iri), .yi(yi), .zi(zi), .zlo(zlo), .read(rd), .write(wr),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .cout(cout),
        .alu_op(alu_op), .halted(halted), .illegal(illegal), .state(state)
    );

    function automatic logic [19:0] m(input int b);
        return 20'(1) << b;
    endfunction

    function automatic logic [19:0] dut_vec();
        return {pco, pci, inc_pc, mari, mdri, mdro, iri, yi, zi, zlo, rd, wr,
                gra, grb, grc, rin, rout, cout, halted, illegal};
    endfunction

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [19:0] strb, input logic [19:0] fo,
                        input logic [3:0] alu, input bit w);
        step_t s;
        s.st = st; s.strb = strb; s.first_only = fo; s.alu = alu; s.waits = w;
        seq.push_back(s);
    endtask

    task automatic start_fetch();
        seq.delete();
        push(4'd1, m(B_PCO) | m(B_MARI) | m(B_INC) | m(B_ZI), 20'd0, 4'd1, 1'b0);
        push(4'd2, m(B_ZLO) | m(B_PCI) | m(B_RD) | m(B_MDRI), m(B_ZLO) | m(B_PCI), 4'd0, 1'b1);
        push(4'd3, m(B_MDRO) | m(B_IRI), 20'd0, 4'd0, 1'b0);
        idx = 0; first = 1'b1; halts_after = 1'b0; mode = 1;
    endtask

    // Execute micro-steps appended once the instruction is in IR
    task automatic push_exec(input logic [31:0] instr);
        int op;
        op = int'(instr[31:27]);
        if (op == 26) begin
            push(4'd4, 20'd0, 20'd0, 4'd0, 1'b0);
        end else if (op == 27) begin
            push(4'd4, 20'd0, 20'd0, 4'd0, 1'b0);
            halts_after = 1'b1;
        end else if (op > 6) begin
            push(4'd4, m(B_ILL), 20'd0, 4'd0, 1'b0);
        end else begin
            push(4'd4, m(B_GRB) | m(B_ROUT) | m(B_YI), 20'd0, 4'd0, 1'b0);
            if (op >= 3) begin
                push(4'd5, m(B_GRC) | m(B_ROUT) | m(B_ZI), 20'd0, 4'(op - 2), 1'b0);
                push(4'd6, m(B_ZLO) | m(B_GRA) | m(B_RIN), 20'd0, 4'd0, 1'b0);
            end else begin
                push(4'd5, m(B_COUT) | m(B_ZI), 20'd0, 4'd1, 1'b0);
                if (op == 1) begin
                    push(4'd6, m(B_ZLO) | m(B_GRA) | m(B_RIN), 20'd0, 4'd0, 1'b0);
                end else begin
                    push(4'd6, m(B_ZLO) | m(B_MARI), 20'd0, 4'd0, 1'b0);
                    if (op == 0) begin
                        push(4'd7, m(B_RD) | m(B_MDRI), 20'd0, 4'd0, 1'b1);
                        push(4'd8, m(B_MDRO) | m(B_GRA) | m(B_RIN), 20'd0, 4'd0, 1'b0);
                    end else begin
                        push(4'd7, m(B_GRA) | m(B_ROUT) | m(B_MDRI), 20'd0, 4'd0, 1'b0);
                        push(4'd8, m(B_WR), 20'd0, 4'd0, 1'b1);
                    end
                end
            end
        end
    endtask

    task automatic model_step(input bit r, input bit mr);
        step_t s;
        if (mode == 0) begin
            if (r) start_fetch();
        end else if (mode == 1) begin
            s = seq[idx];
            if (s.waits && !mr) begin
                first = 1'b0;
            end else begin
                if (idx == 2) push_exec(ir);
                idx++;
                first = 1'b1;
                if (idx == seq.size()) begin
                    if (halts_after) mode = 2;
                    else if (r)      start_fetch();
                    else             mode = 0;
                end
            end
        end
    endtask

    task automatic check();
        step_t s;
        logic [19:0] v, ev;
        logic [3:0]  ea, es;
        v = dut_vec();
        if (mode == 0) begin
            es = 4'd0; ea = 4'd0; ev = 20'd0;
        end else if (mode == 2) begin
            es = 4'd9; ea = 4'd0; ev = m(B_HLT);
        end else begin
            s = seq[idx];
            es = s.st; ea = s.alu;
            ev = first ? s.strb : (s.strb & ~s.first_only);
        end
        vectors++;
        if ({state, alu_op, v} !== {es, ea, ev}) begin
            errors++;
            $display("FAIL cycle t=%0t: got st=%0d alu=%0d strb=%05h expected st=%0d alu=%0d strb=%05h",
                     $time, state, alu_op, v, es, ea, ev);
        end
        vectors++;
        if ((rd && wr) || ($countones({pco, mdro, rout, zlo, cout}) > 1)) begin
            errors++;
            $display("FAIL invariant t=%0t: got strb=%05h required no rd+wr and <=1 bus driver", $time, v);
        end
        tr_st.push_back(state);
        tr_vec.push_back(v);
        tr_alu.push_back(alu_op);
    endtask

    // Called at a negedge; drives, checks, advances the model, returns at the next negedge
    task automatic tick(input bit r, input bit mr);
        run = r; mem_ready = mr;
        #1 check();
        model_step(r, mr);
        @(negedge clock);
    endtask

    task automatic run_pat(input int n, input logic [31:0] rpat, input logic [31:0] mpat);
        for (int i = 0; i < n; i++) tick(rpat[n-1-i], mpat[n-1-i]);
    endtask

    task automatic do_reset();
        #2 clear = 1'b0;
        #1 lit("reset_async", 32'({state, alu_op, dut_vec()}), 32'd0);
        mode = 0;
        seq.delete();
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic clr_trace();
        tr_st.delete(); tr_vec.delete(); tr_alu.delete();
    endtask

    task automatic chk_states(input string name, input int n, input logic [63:0] exp);
        for (int i = 0; i < n; i++)
            lit($sformatf("%s_st[%0d]", name, i), 32'(tr_st[i]), 32'(exp[4*(n-1-i) +: 4]));
    endtask

    task automatic chk_bit(input string name, input int b, input int start, input int n,
                           input logic [15:0] exp);
        for (int i = 0; i < n; i++)
            lit($sformatf("%s[%0d]", name, start + i), 32'(tr_vec[start+i][b]), 32'(exp[n-1-i]));
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] v;
        logic [4:0]  op;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 11);
        if (k <= 6)               op = 5'(k);
        else if (k == 7 || k == 8) op = 5'd26;
        else if (k == 9)          op = 5'd27;
        else if (k == 10)         op = 5'($urandom_range(7, 25));
        else                      op = 5'($urandom_range(28, 31));
        v[31:27] = op;
        return v;
    endfunction

    initial begin
        int hcnt;
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        @(negedge clock);
        lit("reset_state", 32'({state, alu_op, dut_vec()}), 32'd0);
        clear = 1'b1;

        // Reset in the middle of T4 of an AND
        ir = 32'h2891_8000;
        run_pat(5, 32'h1f, 32'h1f);
        lit("pre_reset_t4", 32'(state), 32'd5);
        do_reset();
        run_pat(3, 32'h0, 32'h7);
        lit("idle_after_reset", 32'(state), 32'd0);

        // and R1,R2,R3 with memory always ready
        clr_trace();
        run_pat(8, 32'hff, 32'hff);
        chk_states("and", 8, 64'h0123_4561);
        lit("and_t4_strb", 32'(tr_vec[5]), 32'(m(B_GRC) | m(B_ROUT) | m(B_ZI)));
        lit("and_t4_alu", 32'(tr_alu[5]), 32'd3);
        lit("and_t5_strb", 32'(tr_vec[6]), 32'(m(B_ZLO) | m(B_GRA) | m(B_RIN)));
        do_reset();

        // Fetch with three wait cycles
        ir = 32'hD000_0000;
        clr_trace();
        run_pat(9, 32'h1ff, 32'h18f);
        chk_states("fetchwait", 9, 64'h0_1222_2341);
        chk_bit("fetchwait_pci", B_PCI, 2, 4, 16'b1000);
        chk_bit("fetchwait_read", B_RD, 2, 4, 16'b1111);
        do_reset();

        // ld with two wait cycles in T6, run dropped at T7
        ir = 32'h0080_0064;
        clr_trace();
        run_pat(12, 32'hffc, 32'hfe7);
        chk_states("ld", 12, 64'h0123_4567_7780);
        lit("ld_t5_strb", 32'(tr_vec[6]), 32'(m(B_ZLO) | m(B_MARI)));
        lit("ld_t7_strb", 32'(tr_vec[10]), 32'(m(B_MDRO) | m(B_GRA) | m(B_RIN)));

        // st
        ir = 32'h1080_0010;
        clr_trace();
        run_pat(10, 32'h3fc, 32'h3ff);
        chk_states("st", 10, 64'h01_2345_6780);
        lit("st_t6_strb", 32'(tr_vec[7]), 32'(m(B_GRA) | m(B_ROUT) | m(B_MDRI)));
        lit("st_t7_strb", 32'(tr_vec[8]), 32'(m(B_WR)));

        // Undefined opcode, then halt
        ir = 32'hF800_0000;
        clr_trace();
        run_pat(6, 32'h3f, 32'h3f);
        ir = 32'hD800_0000;
        run_pat(6, 32'h3f, 32'h3f);
        chk_states("ill_halt", 12, 64'h0123_4123_4999);
        chk_bit("ill_pulse", B_ILL, 0, 6, 16'b000010);
        chk_bit("halted", B_HLT, 9, 3, 16'b111);
        do_reset();

        // Random instruction stream
        hcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            if (mode == 0 || (mode == 1 && idx == 0)) ir = rand_ir();
            if (mode == 2) hcnt++;
            else           hcnt = 0;
            if (hcnt > 3 || $urandom_range(0, 299) == 0) do_reset();
            else tick($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired fetch/execute controller for the bus-based CPU datapath.
- Generates the per-cycle control strobes that drive the datapath: register/bus in/out enables, MAR/MDR/IR/PC/Y/Z strobes, ALU op, memory read/write, and register-field select.
- Consumes the instruction register contents and a memory-ready handshake.
- Runs one datapath micro-step per clock.

Parameters:
- OPW, 5, opcode width taken from ir[31:27].
- ALUW, 4, width of the alu_op output.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous reset, active-low; 0 forces IDLE immediately.
- run  in  1  level; starts or continues sequencing from IDLE.
- ir  in  32  current instruction register contents.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pco, pci, inc_pc  out  1 each  PC out to bus / PC in from bus / PC increment select.
- mari, mdri, mdro  out  1 each  MAR in, MDR in, MDR out.
- iri  out  1  IR in.
- yi, zi, zlo  out  1 each  Y in, Z in, Z-low out.
- read, write  out  1 each  memory read / memory write request.
- gra, grb, grc  out  1 each  select the ir ra[26:23] / rb[22:19] / rc[18:15] field as the register address.
- rin, rout  out  1 each  selected register in / out.
- cout  out  1  sign-extended ir[18:0] driven onto the bus.
- alu_op  out  ALUW  ALU function: 0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
- state  out  4  current state encoding, for debug.

Behaviour:
- Moore outputs: every strobe is a pure function of the registered state and ir, and holds for the full cycle.
- Reset: all outputs are 0 (alu_op=PASS, state=IDLE).
- Reset asserted mid-instruction aborts the instruction with no further strobes.
- State encoding: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, T7=8, HALT=9.
- IDLE: no strobes. If run=1 then T0, else stay in IDLE.
- T0: pco, mari, inc_pc, zi, alu_op=ADD.
- T1: zlo, pci, read, mdri. Stays in T1 while mem_ready=0; zlo/pci assert only on the first T1 cycle; read/mdri hold until mem_ready=1, then T2.
- T2: mdro, iri, then T3.
- Opcodes (ir[31:27]): ld=0, ldi=1, st=2, add=3, sub=4, and=5, or=6, nop=26, halt=27.
- Decode is from ir in T3. ir is stable because IR loaded in T2.
- add/sub/and/or:
  - T3: grb, rout, yi.
  - T4: grc, rout, zi, alu_op per opcode.
  - T5: zlo, gra, rin.
- ldi:
  - T3: grb, rout, yi.
  - T4: cout, zi, alu_op=ADD.
  - T5: zlo, gra, rin.
- ld:
  - T3–T4 as for ldi.
  - T5: zlo, mari.
  - T6: read, mdri; wait on mem_ready as in T1.
  - T7: mdro, gra, rin.
- st:
  - T3–T5 as for ld.
  - T6: gra, rout, mdri.
  - T7: write; hold until mem_ready=1.
- End of instruction: the final state goes to T0 if run=1, else IDLE.
- nop: T3 with no strobes, then end of instruction.
- halt: T3 goes to HALT. HALT asserts halted and stays there until clear is asserted; run is ignored.
- Undefined opcode: T3 asserts illegal, then end of instruction (treated as nop).
- Memory waits: if mem_ready=1 on the first wait-state cycle, the state is exactly one cycle long; there is no timeout.
- run deasserted mid-instruction: the instruction completes; run is sampled only at IDLE and at end of instruction.
- Invariants: read and write are never high in the same cycle, and at most one bus driver is active per cycle.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - End of instruction always goes to IDLE.
  - IDLE goes to T0 only on run=1 and a step rising edge, detected with a registered copy of step that resets to 0.
- When undefined:
  - No step port.
  - Behaviour exactly as above.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants;
  - alu_op encodings (PASS/ADD/SUB/AND/OR);
  - the state encoding constants;
  - the ir field bit positions.
- Sub-module ctrl_decode (combinational):
  - maps opcode to a one-hot instruction class (alu, ldi, ld, st, nop, halt, illegal) and its alu_op;
  - the sequencer FSM instantiates it once.

Test Plan:
- Reset with clear=0 mid-T4 → all outputs 0 and state=IDLE in the same cycle; after release with run=0, stays in IDLE.
- run=1, mem_ready=1, ir=0x28918000 (and R1,R2,R3) → states T0,T1,T2,T3,T4,T5 on consecutive cycles, then T0. At T4: grc, rout, zi, alu_op=3. At T5: zlo, gra, rin.
- Fetch with mem_ready held 0 for 3 cycles → T1 lasts 4 cycles; pci pulses on the first cycle only; read high for all 4 cycles.
- ld (ir=0x00800064) with mem_ready low 2 cycles in T6 → sequence T0..T7 with T6 lasting 3 cycles. At T5: mari. At T7: mdro, gra, rin.
- st (ir=0x10800010) → T6: gra, rout, mdri; T7: write=1, read=0 throughout.
- ir opcode 31 → illegal pulses for 1 cycle in T3, then back to T0. Then ir opcode 27 → halted=1, stays in HALT despite run=1 until clear=0.
